cache_mem_bridge: RTL and testbench
===================================

# cache_mem_bridge

Memory-side responder for the data cache's line transfer interface. Accepts a dirty-line write-back request (`save_data` + `write_back_data`) and answers with `save_ready`. Accepts a line-fill request and returns the 128-bit line on `write_load_data`. Translates each 16-byte line into four 32-bit beats on a simple req/ack word bus toward main memory or the bus fabric.

## Interface
- `LINE_BYTES`, default 16: cache line size in bytes; fixed at 16, four beats.
- `WORD_W`, default 32: memory word width, equal to XLEN.
- `ADDR_W`, default 32: address width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `save_data` in 1: write-back request, level; held until `save_ready` is seen.
- `wb_addr` in 32: any address inside the victim line; stable while `save_data` is high.
- `write_back_data` in 128: victim line; stable while `save_data` is high.
- `save_ready` out 1: write-back complete; held high until `save_data` is low.
- `load_req` in 1: fill request, level.
- `line_addr` in 32: any address inside the line to fill; stable while `load_req` is high.
- `write_load_data` out 128: filled line, registered.
- `load_valid` out 1: fill complete and `write_load_data` valid; held high until `load_req` is low.
- `mem_req` out 1: beat request.
- `mem_we` out 1: 1 = write beat, 0 = read beat.
- `mem_addr` out 32: word address of the current beat.
- `mem_wdata` out 32: write data for the current beat.
- `mem_rdata` in 32: read data; valid in any cycle where `mem_ack` is high on a read beat.
- `mem_ack` in 1: beat accepted or completed; sampled at the rising edge of `clk`.

## Operation
- States:
  - IDLE
  - WB: write-back beats.
  - WB_DONE
  - FILL: fill beats.
  - FILL_DONE
- A 2-bit beat counter `beat` runs 0 to 3.
- Line base address = request address with bits [3:0] cleared.
- `mem_addr` = base + 4·beat. The lower two bits are always 0.
- Beat k carries line bits [32k+31:32k], so the lowest address maps to the lowest bits (byte offset·8 ordering).
- IDLE:
  - If `save_data` is high, go to WB with beat = 0.
  - Else if `load_req` is high, go to FILL with beat = 0.
  - `save_data` has priority when both are high.
- WB:
  - `mem_req` = 1, `mem_we` = 1, `mem_wdata` = `write_back_data`[32·beat +: 32].
  - On `mem_ack`, beat increments.
  - On `mem_ack` while beat = 3, go to WB_DONE.
- WB_DONE:
  - `save_ready` = 1.
  - When `save_data` is low, go to IDLE.
- FILL:
  - `mem_req` = 1, `mem_we` = 0.
  - On `mem_ack`, `write_load_data`[32·beat +: 32] <= `mem_rdata` and beat increments.
  - On `mem_ack` while beat = 3, go to FILL_DONE.
- FILL_DONE:
  - `load_valid` = 1.
  - When `load_req` is low, go to IDLE.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` hold stable from the first cycle of a beat until the edge where `mem_ack` is sampled.
- After an ack, the next beat is presented in the following cycle, with no idle cycle between beats.
- `mem_ack` is ignored whenever `mem_req` is low.
- While not in IDLE, new requests and changes on the non-active request line are ignored. A `load_req` raised during a write-back is served after the return to IDLE.
- `write_load_data` keeps its last value outside FILL.
- Reset values:
  - State = IDLE, beat = 0.
  - `save_ready`, `load_valid`, `mem_req`, `mem_we` = 0.
  - `mem_addr`, `mem_wdata`, `write_load_data` = 0.
- Reset asserted mid-transfer: outputs drop to reset values immediately (asynchronously). The partial transfer is abandoned and not resumed after reset releases.

## Timing
- `save_ready`, `load_valid` and `mem_*` are decoded from registered state and registered beat/data. There are no combinational paths from any input to any output.
- Request sampled in IDLE at edge 0 → first beat presented in cycle 1.
- With zero-wait memory (`mem_ack` high in the same cycle as `mem_req`):
  - The four beats occupy cycles 1–4.
  - `save_ready` / `load_valid` rise in cycle 5.
- With w wait cycles per beat: done flag rises at cycle 1 + 4·(w+1).
- The cache drops `save_data` or `load_req` in the same cycle it sees the done flag. The done flag is then low in the next cycle, and a new request can be sampled in IDLE the cycle after that.

## Test plan
- **Reset:** hold `rst` low with random inputs → all outputs 0. Release, drive `mem_ack` = 1 with no request → `mem_req` stays 0.
- **Zero-wait write-back:**
  - Stimulus: `wb_addr` = 0x0000_1234, `write_back_data` = 0x44444444_33333333_22222222_11111111.
  - Required beats: writes to 0x1230/0x1234/0x1238/0x123C with data 0x11111111/0x22222222/0x33333333/0x44444444 in cycles 1–4.
  - `save_ready` = 1 in cycle 5 and held until `save_data` drops.
- **Fill with 2 wait states:**
  - Stimulus: `line_addr` = 0x8000_0048; memory returns 0xA0, 0xA1, 0xA2, 0xA3 for 0x80000040–0x8000004C, each acked on the 3rd cycle of `mem_req`.
  - `mem_addr` is held stable during waits.
  - `load_valid` rises in cycle 13 with `write_load_data` = {0xA3, 0xA2, 0xA1, 0xA0}.
- **Simultaneous requests:** `save_data` and `load_req` rise together → four write beats, `save_ready` handshake, then four read beats, then `load_valid`.
- **Reset mid-fill:** pull `rst` low during beat 2 → `mem_req` goes to 0 immediately. After release: IDLE, `load_valid` = 0, and a fresh fill completes correctly.
- **Stray ack and hold:** pulse `mem_ack` while idle → no beat is consumed. Keep `load_req` high 5 extra cycles after `load_valid` → `load_valid` and data stay stable, with no new `mem_req`.

Source files
------------

// File: rtl/cache_mem_bridge.sv
// Cache line transfer responder: splits 16-byte write-backs and fills
// into four 32-bit req/ack beats toward memory.
module cache_mem_bridge #(
   parameter int LINE_BYTES = 16,
   parameter int WORD_W     = 32,
   parameter int ADDR_W     = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    save_data,
   input  logic [ADDR_W-1:0]       wb_addr,
   input  logic [LINE_BYTES*8-1:0] write_back_data,
   output logic                    save_ready,
   input  logic                    load_req,
   input  logic [ADDR_W-1:0]       line_addr,
   output logic [LINE_BYTES*8-1:0] write_load_data,
   output logic                    load_valid,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [WORD_W-1:0]       mem_wdata,
   input  logic [WORD_W-1:0]       mem_rdata,
   input  logic                    mem_ack
);

   localparam int LINE_W = LINE_BYTES * 8;
   localparam int BEATS  = LINE_W / WORD_W;
   localparam int BW     = $clog2(BEATS);
   localparam int OFF_W  = $clog2(LINE_BYTES);
   localparam int WOFF   = $clog2(WORD_W / 8);
   localparam int BASE_W = ADDR_W - OFF_W;

   typedef enum logic [2:0] {
      IDLE,
      WB,
      WB_DONE,
      FILL,
      FILL_DONE
   } state_e;

   state_e              state_q, state_d;
   logic [BW-1:0]       beat_q, beat_d;
   logic [BASE_W-1:0]   base_q, base_d;
   logic [LINE_W-1:0]   wb_line_q, wb_line_d;
   logic [LINE_W-1:0]   rd_line_q, rd_line_d;
   logic                last_beat;
   logic                unused_lsb;

   // Offset bits inside the line never reach the word bus.
   assign unused_lsb = ^{wb_addr[OFF_W-1:0], line_addr[OFF_W-1:0]};

   assign last_beat = (beat_q == BW'(BEATS - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         beat_q    <= '0;
         base_q    <= '0;
         wb_line_q <= '0;
         rd_line_q <= '0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         base_q    <= base_d;
         wb_line_q <= wb_line_d;
         rd_line_q <= rd_line_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      base_d    = base_q;
      wb_line_d = wb_line_q;
      rd_line_d = rd_line_q;
      unique case (state_q)
         IDLE: begin
            if (save_data) begin
               state_d   = WB;
               beat_d    = '0;
               base_d    = wb_addr[ADDR_W-1:OFF_W];
               wb_line_d = write_back_data;
            end else if (load_req) begin
               state_d = FILL;
               beat_d  = '0;
               base_d  = line_addr[ADDR_W-1:OFF_W];
            end
         end
         WB: begin
            if (mem_ack) begin
               beat_d = beat_q + BW'(1);
               if (last_beat) state_d = WB_DONE;
            end
         end
         WB_DONE: begin
            if (!save_data) state_d = IDLE;
         end
         FILL: begin
            if (mem_ack) begin
               rd_line_d[beat_q*WORD_W +: WORD_W] = mem_rdata;
               beat_d = beat_q + BW'(1);
               if (last_beat) state_d = FILL_DONE;
            end
         end
         FILL_DONE: begin
            if (!load_req) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // All outputs decode registered state only.
   always_comb begin
      mem_req         = 1'b0;
      mem_we          = 1'b0;
      mem_addr        = '0;
      mem_wdata       = '0;
      save_ready      = 1'b0;
      load_valid      = 1'b0;
      write_load_data = rd_line_q;
      unique case (state_q)
         WB: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {base_q, beat_q, {WOFF{1'b0}}};
            mem_wdata = wb_line_q[beat_q*WORD_W +: WORD_W];
         end
         FILL: begin
            mem_req  = 1'b1;
            mem_addr = {base_q, beat_q, {WOFF{1'b0}}};
         end
         WB_DONE:   save_ready = 1'b1;
         FILL_DONE: load_valid = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Randomized bench for cache_mem_bridge against a beat-queue model
// and a wait-state memory responder.
module tb_cache_mem_bridge;

   logic         clk = 1'b0;
   logic         rst;
   logic         save_data;
   logic [31:0]  wb_addr;
   logic [127:0] write_back_data;
   logic         save_ready;
   logic         load_req;
   logic [31:0]  line_addr;
   logic [127:0] write_load_data;
   logic         load_valid;
   logic         mem_req;
   logic         mem_we;
   logic [31:0]  mem_addr;
   logic [31:0]  mem_wdata;
   logic [31:0]  mem_rdata;
   logic         mem_ack;

   cache_mem_bridge dut (
      .clk(clk),
      .rst(rst),
      .save_data(save_data),
      .wb_addr(wb_addr),
      .write_back_data(write_back_data),
      .save_ready(save_ready),
      .load_req(load_req),
      .line_addr(line_addr),
      .write_load_data(write_load_data),
      .load_valid(load_valid),
      .mem_req(mem_req),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a[31:4] == 28'h8000004) return 32'hA0 + {30'd0, a[3:2]};
      return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
   endfunction

   // Memory responder
   int w_fixed = 0;
   bit stray_en = 0;
   bit stray_force = 0;
   bit in_beat = 0;
   int cnt = 0;
   int cur_wait = 0;

   initial begin
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            mem_ack = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            in_beat = 0;
            cnt = 0;
         end else if (mem_req) begin
            if (!in_beat) begin
               cur_wait = (w_fixed >= 0) ? w_fixed : $urandom_range(0, 3);
               in_beat = 1;
               cnt = 0;
            end
            if (cnt >= cur_wait) begin
               mem_ack = 1'b1;
               mem_rdata = mem_word(mem_addr);
               in_beat = 0;
            end else begin
               mem_ack = 1'b0;
               mem_rdata = $urandom;
               cnt++;
            end
         end else begin
            mem_ack = stray_force ? 1'b1 :
                      (stray_en ? 1'($urandom_range(0, 1)) : 1'b0);
            mem_rdata = $urandom;
            in_beat = 0;
         end
      end
   end

   // Transaction model: a queue of outstanding beats plus a done flag.
   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
   } beat_t;

   beat_t        q[$];
   int           done_k = 0;
   int           cur_kind = 0;
   logic [127:0] pend_line = '0;
   logic [127:0] exp_wld = '0;

   initial begin
      logic [31:0] b;
      beat_t       e;
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            q.delete();
            done_k = 0;
            cur_kind = 0;
            exp_wld = '0;
         end else if (q.size() > 0) begin
            if (mem_ack) begin
               q.delete(0);
               if (q.size() == 0) begin
                  done_k = cur_kind;
                  if (cur_kind == 2) exp_wld = pend_line;
               end
            end
         end else if (done_k == 1) begin
            if (!save_data) done_k = 0;
         end else if (done_k == 2) begin
            if (!load_req) done_k = 0;
         end else if (save_data) begin
            b = {wb_addr[31:4], 4'h0};
            for (int k = 0; k < 4; k++) begin
               e.addr = b + 32'(4 * k);
               e.we = 1'b1;
               e.wdata = write_back_data[32*k +: 32];
               q.push_back(e);
            end
            cur_kind = 1;
         end else if (load_req) begin
            b = {line_addr[31:4], 4'h0};
            for (int k = 0; k < 4; k++) begin
               e.addr = b + 32'(4 * k);
               e.we = 1'b0;
               e.wdata = '0;
               q.push_back(e);
               pend_line[32*k +: 32] = mem_word(e.addr);
            end
            cur_kind = 2;
         end
      end
   end

   // Per-cycle compare against the model
   initial begin
      forever begin
         @(negedge clk);
         chk("mem_req", 128'(mem_req), 128'(q.size() > 0));
         chk("save_ready", 128'(save_ready), 128'(done_k == 1));
         chk("load_valid", 128'(load_valid), 128'(done_k == 2));
         if (q.size() > 0) begin
            chk("mem_we", 128'(mem_we), 128'(q[0].we));
            chk("mem_addr", 128'(mem_addr), 128'(q[0].addr));
            if (q[0].we) chk("mem_wdata", 128'(mem_wdata), 128'(q[0].wdata));
         end
         if (!(q.size() > 0 && !q[0].we))
            chk("write_load_data", write_load_data, exp_wld);
      end
   end

   task automatic wait_flag(input int which, output int cyc);
      logic f;
      cyc = 0;
      f = 1'b0;
      while (!f && cyc < 400) begin
         @(negedge clk);
         cyc++;
         f = (which == 0) ? save_ready : load_valid;
      end
      n_vec++;
      if (!f) begin
         n_err++;
         $display("FAIL timeout flag%0d: got 0 want 1 within 400 cycles", which);
      end
   endtask

   task automatic do_xact(input int kind, input int hold);
      int cyc;
      @(negedge clk);
      wb_addr = $urandom;
      line_addr = $urandom;
      write_back_data = {$urandom, $urandom, $urandom, $urandom};
      if (kind != 2) save_data = 1'b1;
      if (kind != 1) load_req = 1'b1;
      if (kind != 2) begin
         wait_flag(0, cyc);
         repeat (hold) @(negedge clk);
         save_data = 1'b0;
      end
      if (kind != 1) begin
         wait_flag(1, cyc);
         repeat (hold) @(negedge clk);
         load_req = 1'b0;
      end
   endtask

   logic [31:0] wexp [4];
   logic [31:0] lb;

   initial begin
      int cyc;
      int guard;
      wexp[0] = 32'h11111111;
      wexp[1] = 32'h22222222;
      wexp[2] = 32'h33333333;
      wexp[3] = 32'h44444444;

      // Reset with random inputs
      rst = 1'b0;
      save_data = 1'b0;
      load_req = 1'b0;
      wb_addr = '0;
      line_addr = '0;
      write_back_data = '0;
      repeat (4) begin
         @(negedge clk);
         save_data = 1'($urandom_range(0, 1));
         load_req = 1'($urandom_range(0, 1));
         wb_addr = $urandom;
         line_addr = $urandom;
         write_back_data = {$urandom, $urandom, $urandom, $urandom};
         #1;
         chk("reset_outs",
             {save_ready, load_valid, mem_req, mem_we, mem_addr, mem_wdata},
             '0);
         chk("reset_wld", write_load_data, '0);
      end
      @(negedge clk);
      save_data = 1'b0;
      load_req = 1'b0;
      stray_force = 1;
      @(posedge clk);
      #2 rst = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("idle_ack_no_req", 128'(mem_req), 128'd0);
      end
      stray_force = 0;

      // Zero-wait write-back
      w_fixed = 0;
      @(negedge clk);
      wb_addr = 32'h0000_1234;
      write_back_data = 128'h44444444_33333333_22222222_11111111;
      save_data = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("wb_beat_req", {mem_req, mem_we}, 2'b11);
         chk("wb_beat_addr", 128'(mem_addr), 128'(32'h1230 + 32'(4 * c)));
         chk("wb_beat_data", 128'(mem_wdata), 128'(wexp[c]));
      end
      @(negedge clk);
      chk("wb_ready_c5", 128'(save_ready), 128'd1);
      repeat (2) begin
         @(negedge clk);
         chk("wb_ready_hold", 128'(save_ready), 128'd1);
      end
      save_data = 1'b0;
      @(negedge clk);
      chk("wb_ready_drop", 128'(save_ready), 128'd0);

      // Fill with two wait states, then hold with stray acks
      w_fixed = 2;
      @(negedge clk);
      line_addr = 32'h8000_0048;
      load_req = 1'b1;
      wait_flag(1, cyc);
      chk("fill_cycle", 128'(cyc), 128'd13);
      chk("fill_line", write_load_data,
          128'h000000A3_000000A2_000000A1_000000A0);
      stray_en = 1;
      repeat (5) begin
         @(negedge clk);
         chk("hold_valid", 128'(load_valid), 128'd1);
         chk("hold_noreq", 128'(mem_req), 128'd0);
         chk("hold_line", write_load_data,
             128'h000000A3_000000A2_000000A1_000000A0);
      end
      load_req = 1'b0;
      repeat (2) @(negedge clk);
      stray_en = 0;

      // Simultaneous requests
      w_fixed = 0;
      do_xact(3, 1);

      // Reset during beat 2 of a fill
      w_fixed = 1;
      @(negedge clk);
      lb = $urandom;
      line_addr = lb;
      load_req = 1'b1;
      guard = 0;
      while (!(mem_req && mem_addr[3:2] == 2'd2) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      chk("reach_beat2", 128'(guard < 100), 128'd1);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("midrst_req", 128'(mem_req), 128'd0);
      chk("midrst_valid", 128'(load_valid), 128'd0);
      chk("midrst_line", write_load_data, '0);
      @(negedge clk);
      load_req = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("postrst_idle", {mem_req, load_valid}, 2'b00);
      end
      @(negedge clk);
      lb = 32'h0000_5A5C;
      line_addr = lb;
      load_req = 1'b1;
      wait_flag(1, cyc);
      chk("refill_line", write_load_data,
          {mem_word(32'h5A5C), mem_word(32'h5A58),
           mem_word(32'h5A54), mem_word(32'h5A50)});
      load_req = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 40; i++) begin
         w_fixed = int'($urandom_range(0, 4)) - 1;
         stray_en = 1'($urandom_range(0, 1));
         do_xact(int'($urandom_range(1, 3)), int'($urandom_range(0, 3)));
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            wb_addr = $urandom;
            line_addr = $urandom;
            write_back_data = {$urandom, $urandom, $urandom, $urandom};
         end
      end
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
